seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Holds one hex nibble per digit, drives each digit for SCAN_DIV clocks with
// the anode enabled one cycle late to match the external registered decoder,
// then blanks all anodes for BLANK_CYCLES clocks before moving to the next digit.
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  output logic [3:0]            hex_out,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_done
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       hex_q, hex_d;
  logic [3:0]       digit_q [NUM_DIGITS];
  logic             wr_hit;
  logic             suppress;

  // The digit currently on the display is locked against writes while driven.
  assign wr_ready = !((state_q == DRIVE) && (wr_addr == 3'(idx_q)));
  // Out-of-range addresses handshake normally but never touch storage.
  assign wr_hit   = wr_valid && wr_ready && ({1'b0, wr_addr} < 4'(NUM_DIGITS));

  // Digit storage, written through the valid/ready port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'h0;
    end else if (wr_hit) begin
      digit_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Scan state, digit index, shared prescaler/blank counter and nibble register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
    end
  end

  // Next-state logic; dropping en abandons the current period immediately.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      hex_d   = 4'h0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          hex_d   = digit_q[0];
        end
        DRIVE: begin
          // Refresh every cycle so a write landing on the entry edge shows one cycle later.
          hex_d = digit_q[idx_q];
          if (cnt_q == DRIVE_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            hex_d   = digit_q[idx_d];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          hex_d   = 4'h0;
        end
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] upper_zero;

  // upper_zero[i] is set when digits NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    logic acc;
    upper_zero = '0;
    acc        = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      acc           = acc && (digit_q[i] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  assign suppress = (idx_q != '0) && upper_zero[idx_q];
`else
  assign suppress = 1'b0;
`endif

  // Anode enable lags DRIVE entry by one cycle to align with decoder latency.
  always_comb begin
    anode_n = '1;
    if ((state_q == DRIVE) && (cnt_q != '0) && !suppress) anode_n[idx_q] = 1'b0;
  end

  assign hex_out    = hex_q;
  assign frame_done = en && (state_q == BLANK) && (cnt_q == BLANK_LAST) && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, write handshake, enable
// drop, asynchronous reset and (when built with it) leading zero blanking.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] hex_out;
  logic [3:0] anode_n;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .hex_out   (hex_out),
    .anode_n   (anode_n),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One write through the port, issued and released on falling edges.
  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
    $display("write addr=%0d data=0x%0h", a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] hex_tab [4];
    logic [3:0] exp_an;
    int d;
    int p;
    hex_tab[0] = 4'h4; hex_tab[1] = 4'h3; hex_tab[2] = 4'h2; hex_tab[3] = 4'h1;

    rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_anode", 32'(anode_n), 32'hF);
    check("rst_hex", 32'(hex_out), 32'h0);
    check("rst_frame", 32'(frame_done), 32'h0);
    check("rst_ready", 32'(wr_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Load digits 3..0 = 1,2,3,4 while idle.
    wr(3'd3, 4'h1); wr(3'd2, 4'h2); wr(3'd1, 4'h3); wr(3'd0, 4'h4);
    check("idle_anode", 32'(anode_n), 32'hF);
    check("idle_hex", 32'(hex_out), 32'h0);

    // Two full frames: each digit 5 cycles (4 drive + 1 blank), anode low on phases 1..3.
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      d = (k % 20) / 5;
      p = k % 5;
      exp_an = (p >= 1 && p <= 3) ? ~(4'b0001 << d) : 4'hF;
      check("scan_hex", 32'(hex_out), 32'(hex_tab[d]));
      check("scan_anode", 32'(anode_n), 32'(exp_an));
      check("scan_frame", 32'(frame_done), (k % 20 == 19) ? 32'h1 : 32'h0);
      $display("scan k=%0d hex=%0h anode=%b frame=%0b", k, hex_out, anode_n, frame_done);
      @(negedge clk);
    end

    // k=40: write to the digit being driven is held off until BLANK.
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h9;
    #1 check("busy_ready", 32'(wr_ready), 32'h0);
    for (int k = 41; k < 44; k++) begin
      @(negedge clk);
      check("busy_ready", 32'(wr_ready), 32'h0);
    end
    @(negedge clk);
    check("blank_ready", 32'(wr_ready), 32'h1);
    check("blank_hex_held", 32'(hex_out), 32'h4);
    @(negedge clk);
    wr_valid = 1'b0;
    check("next_digit_hex", 32'(hex_out), 32'h3);
    $display("held write accepted in blank");
    repeat (15) @(negedge clk);
    check("new_frame_hex", 32'(hex_out), 32'h9);
    check("new_frame_anode", 32'(anode_n), 32'hF);
    @(negedge clk);
    check("new_frame_anode1", 32'(anode_n), 32'hE);

    // k=61 -> k=71: mid-DRIVE of idx 2, then drop en.
    repeat (10) @(negedge clk);
    check("idx2_anode", 32'(anode_n), 32'hB);
    en = 1'b0;
    @(negedge clk);
    check("drop_anode", 32'(anode_n), 32'hF);
    check("drop_hex", 32'(hex_out), 32'h0);
    check("drop_frame", 32'(frame_done), 32'h0);
    en = 1'b1;
    @(negedge clk);
    check("restart_hex", 32'(hex_out), 32'h9);
    check("restart_anode", 32'(anode_n), 32'hF);
    @(negedge clk);
    check("restart_anode1", 32'(anode_n), 32'hE);
    $display("enable drop and restart done");

    // Asynchronous reset while digit 0 is lit.
    #2 rst_n = 1'b0;
    #1;
    check("async_anode", 32'(anode_n), 32'hF);
    check("async_hex", 32'(hex_out), 32'h0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 4'hF;
    #1 check("oob_ready", 32'(wr_ready), 32'h1);
    @(negedge clk);
    wr_addr = 3'd6;
    @(negedge clk);
    wr_valid = 1'b0;
    $display("reset and out-of-range writes done");

    // Scan after reset: all digits 0, except digit 1 written on its DRIVE entry edge.
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      d = k / 5;
      p = k % 5;
      if (k == 6) check("late_write_hex", 32'(hex_out), 32'h7);
      if (p == 2) begin
        check("post_rst_hex", 32'(hex_out), (d == 1) ? 32'h7 : 32'h0);
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = (d >= 2) ? 4'hF : ~(4'b0001 << d);
`else
        exp_an = ~(4'b0001 << d);
`endif
        check("post_rst_anode", 32'(anode_n), 32'(exp_an));
      end
      if (k == 19) check("post_rst_frame", 32'(frame_done), 32'h1);
      $display("post-reset k=%0d hex=%0h anode=%b", k, hex_out, anode_n);
      if (k == 4) begin
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 4'h7;
      end
      if (k == 5) wr_valid = 1'b0;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
